// File: rtl/capture_ctrl_if.sv
// Handshake and RAM-side bundle between the capture sequencer and its neighbours.
// The master modport is the surrounding logic; the slave modport is capture_ctrl.
interface capture_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              stop;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_pos;
    logic              smpl_en;
    logic              triggered;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              armed;
    logic              trig_en;
    logic              set_capture_done;
    logic [ADDR_W-1:0] trace_end;
    logic              busy;

    modport master (
        output start, stop, capture_done, trig_pos, smpl_en, triggered,
        input  we, waddr, armed, trig_en, set_capture_done, trace_end, busy
    );

    modport slave (
        input  start, stop, capture_done, trig_pos, smpl_en, triggered,
        output we, waddr, armed, trig_en, set_capture_done, trace_end, busy
    );
endinterface

// File: rtl/capture_ctrl.sv
// Sample-capture sequencer: circular RAM writes, pre-trigger arming, post-trigger count.
// Define CAPTURE_ADDR_CLR_EN to restart every capture at RAM address 0.
module capture_ctrl #(
    parameter int ENTRIES = 512,
    parameter int ADDR_W  = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    capture_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   ENTRIES_W = (ADDR_W+1)'(ENTRIES);
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    state_t            state_r, state_nxt;
    logic [ADDR_W:0]   smpl_cnt_r, smpl_cnt_nxt;
    logic [ADDR_W-1:0] post_cnt_r, post_cnt_nxt;
    logic [ADDR_W-1:0] trig_pos_r, trig_pos_nxt;
    logic [ADDR_W-1:0] waddr_r, waddr_nxt;
    logic [ADDR_W-1:0] trace_end_r, trace_end_nxt;
    logic              armed_r, armed_nxt;
    logic              trig_en_r;
    logic              scd_r, scd_nxt;
    logic              we_s;
    logic              post_last_s;

    // Once post_cnt reaches trig_pos the POST state must not write again.
    assign we_s = bus.smpl_en &&
                  ((state_r == PRE) || ((state_r == POST) && (post_cnt_r != trig_pos_r)));

    assign post_last_s = (({1'b0, post_cnt_r} + {{ADDR_W{1'b0}}, we_s}) == {1'b0, trig_pos_r});

    // Next-state, counter and latch computation.
    always_comb begin
        state_nxt     = state_r;
        smpl_cnt_nxt  = smpl_cnt_r;
        post_cnt_nxt  = post_cnt_r;
        trig_pos_nxt  = trig_pos_r;
        trace_end_nxt = trace_end_r;
        scd_nxt       = 1'b0;
        waddr_nxt     = we_s ? (waddr_r + ADDR_ONE) : waddr_r;
        if (bus.stop) begin
            state_nxt = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start && !bus.capture_done) begin
                        state_nxt    = PRE;
                        trig_pos_nxt = bus.trig_pos;
                        smpl_cnt_nxt = {(ADDR_W+1){1'b0}};
                        post_cnt_nxt = ADDR_ZERO;
`ifdef CAPTURE_ADDR_CLR_EN
                        waddr_nxt    = ADDR_ZERO;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                PRE: begin
                    if (we_s && (smpl_cnt_r != ENTRIES_W)) begin
                        smpl_cnt_nxt = smpl_cnt_r + CNT_ONE;
                    end else begin
                        smpl_cnt_nxt = smpl_cnt_r;
                    end
                    // A sample coinciding with the trigger is still a pre-trigger sample.
                    if (bus.triggered) begin
                        state_nxt = POST;
                    end else begin
                        state_nxt = PRE;
                    end
                end
                POST: begin
                    if (we_s) begin
                        post_cnt_nxt = post_cnt_r + ADDR_ONE;
                    end else begin
                        post_cnt_nxt = post_cnt_r;
                    end
                    if (post_last_s) begin
                        state_nxt     = DONE;
                        scd_nxt       = 1'b1;
                        trace_end_nxt = waddr_nxt - ADDR_ONE;
                    end else begin
                        state_nxt = POST;
                    end
                end
                DONE: begin
                    if (!bus.capture_done) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        armed_nxt = (state_nxt == PRE) &&
                    (smpl_cnt_nxt >= (ENTRIES_W - {1'b0, trig_pos_nxt}));
    end

    // State, counters and registered output decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            smpl_cnt_r  <= {(ADDR_W+1){1'b0}};
            post_cnt_r  <= ADDR_ZERO;
            trig_pos_r  <= ADDR_ZERO;
            waddr_r     <= ADDR_ZERO;
            trace_end_r <= ADDR_ZERO;
            armed_r     <= 1'b0;
            trig_en_r   <= 1'b0;
            scd_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            smpl_cnt_r  <= smpl_cnt_nxt;
            post_cnt_r  <= post_cnt_nxt;
            trig_pos_r  <= trig_pos_nxt;
            waddr_r     <= waddr_nxt;
            trace_end_r <= trace_end_nxt;
            armed_r     <= armed_nxt;
            trig_en_r   <= (state_nxt == PRE);
            scd_r       <= scd_nxt;
        end
    end

    assign bus.we               = we_s;
    assign bus.waddr            = waddr_r;
    assign bus.armed            = armed_r;
    assign bus.trig_en          = trig_en_r;
    assign bus.set_capture_done = scd_r;
    assign bus.trace_end        = trace_end_r;
    assign bus.busy             = (state_r != IDLE);
endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: behavioural model, write-address scoreboard,
// a vector table for the main capture and directed sequences for the corner cases.
module tb_capture_ctrl;
    localparam int ENTRIES = 512;
    localparam int ADDR_W  = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    capture_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int exp_q[$];

    // Model state: 0 IDLE, 1 PRE, 2 POST, 3 DONE
    int ms, mwa, msc, mpc, mtp, mte;
    bit mscd;

    typedef struct {
        bit st, sp, cd, se, tr;
        int tp;
        int n;
        bit e_busy, e_armed, e_ten, e_scd;
    } vec_t;
    vec_t tbl[11];

    task automatic cmp(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_we();
        return bus.smpl_en && ((ms == 1) || ((ms == 2) && (mpc != mtp)));
    endfunction

    task automatic model_reset();
        ms = 0; mwa = 0; msc = 0; mpc = 0; mtp = 0; mte = 0; mscd = 1'b0;
        exp_q.delete();
    endtask

    task automatic check();
        bit e_we;
        int a;
        e_we = m_we();
        if (e_we) exp_q.push_back(mwa);
        cmp("we", int'(bus.we), int'(e_we));
        cmp("waddr", int'(bus.waddr), mwa);
        cmp("armed", int'(bus.armed), int'((ms == 1) && (msc >= ENTRIES - mtp)));
        cmp("trig_en", int'(bus.trig_en), int'(ms == 1));
        cmp("busy", int'(bus.busy), int'(ms != 0));
        cmp("set_capture_done", int'(bus.set_capture_done), int'(mscd));
        cmp("trace_end", int'(bus.trace_end), mte);
        if (bus.we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_write: got write at %0d expected no write", int'(bus.waddr));
            end else begin
                a = exp_q.pop_front();
                cmp("sb_waddr", int'(bus.waddr), a);
            end
        end else if (exp_q.size() != 0) begin
            a = exp_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL sb_write: got no write expected write at %0d", a);
        end
    endtask

    task automatic step();
        int ns, nwa, nsc, npc, nte;
        bit nscd, w;
        w = m_we();
        ns = ms; nsc = msc; npc = mpc; nte = mte; nscd = 1'b0;
        nwa = w ? (mwa + 1) % ENTRIES : mwa;
        if (bus.stop) begin
            ns = 0;
        end else if (ms == 0) begin
            if (bus.start && !bus.capture_done) begin
                ns = 1; mtp = int'(bus.trig_pos); nsc = 0; npc = 0;
`ifdef CAPTURE_ADDR_CLR_EN
                nwa = 0;
`endif
            end
        end else if (ms == 1) begin
            if (w && msc < ENTRIES) nsc = msc + 1;
            if (bus.triggered) ns = 2;
        end else if (ms == 2) begin
            if (w) npc = mpc + 1;
            if (npc == mtp) begin
                ns = 3; nscd = 1'b1; nte = (nwa + ENTRIES - 1) % ENTRIES;
            end
        end else if (!bus.capture_done) begin
            ns = 0;
        end
        ms = ns; mwa = nwa; msc = nsc; mpc = npc; mte = nte; mscd = nscd;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic rest();
        check();
        if (rst_n) step(); else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(int n);
        for (int i = 0; i < n; i++) begin
            half();
            rest();
        end
    endtask

    task automatic drive(bit st, bit sp, bit cd, bit se, bit tr, int tp);
        bus.start = st; bus.stop = sp; bus.capture_done = cd;
        bus.smpl_en = se; bus.triggered = tr; bus.trig_pos = ADDR_W'(tp);
    endtask

    initial begin
        int te_before, wr0, exp_resume;
        bit got;

        // Main capture: trig_pos=100, trigger on the 600th write, then host handshake
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1,   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100, 412, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100, 1,   1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100, 186, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 100, 1,   1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100, 100, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100, 1,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 100, 3,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 100, 1,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 1,   1'b0, 1'b0, 1'b0, 1'b0};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        model_reset();
        #2;
        cmp("reset_busy", int'(bus.busy), 0);
        cmp("reset_waddr", int'(bus.waddr), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        wr_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].cd, tbl[i].se, tbl[i].tr, tbl[i].tp);
            cyc(tbl[i].n - 1);
            half();
            cmp($sformatf("row%0d_busy", i), int'(bus.busy), int'(tbl[i].e_busy));
            cmp($sformatf("row%0d_armed", i), int'(bus.armed), int'(tbl[i].e_armed));
            cmp($sformatf("row%0d_trig_en", i), int'(bus.trig_en), int'(tbl[i].e_ten));
            cmp($sformatf("row%0d_scd", i), int'(bus.set_capture_done), int'(tbl[i].e_scd));
            rest();
        end
        cmp("main_total_writes", wr_cnt, 700);
        cmp("main_trace_end", int'(bus.trace_end), 187);

        // trig_pos=0: armed needs a full RAM, POST exits with no writes
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        cyc(511);
        half(); cmp("tp0_armed_511", int'(bus.armed), 0); rest();
        half(); cmp("tp0_armed_512", int'(bus.armed), 1); rest();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        half();
        cmp("tp0_post_busy", int'(bus.busy), 1);
        cmp("tp0_post_we", int'(bus.we), 0);
        cmp("tp0_post_scd", int'(bus.set_capture_done), 0);
        rest();
        half();
        cmp("tp0_scd", int'(bus.set_capture_done), 1);
        cmp("tp0_done_we", int'(bus.we), 0);
        rest();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(2);

        // smpl_en coinciding with triggered, trig_pos=3
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        cyc(5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        cyc(1);
        wr0 = wr_cnt;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            half();
            got = bus.set_capture_done;
            rest();
        end
        cmp("coinc_scd_seen", int'(got), 1);
        cmp("coinc_post_writes", wr_cnt - wr0, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        cyc(2);

        // stop during POST, then a start with capture_done=1
        te_before = mte;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 50);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 50);
        cyc(10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 50);
        cyc(6);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 50);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 50);
        half();
        cmp("stop_busy", int'(bus.busy), 0);
        cmp("stop_scd", int'(bus.set_capture_done), 0);
        cmp("stop_trace_end", int'(bus.trace_end), te_before);
        rest();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 50);
        cyc(1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 50);
        half(); cmp("cdone_start_ignored", int'(bus.busy), 0); rest();

        // Reset mid-PRE with a sample strobe active
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        cyc(20);
        rst_n = 1'b0;
        #1;
        cmp("rst_we", int'(bus.we), 0);
        cmp("rst_armed", int'(bus.armed), 0);
        cmp("rst_busy", int'(bus.busy), 0);
        cmp("rst_waddr", int'(bus.waddr), 0);
        cmp("rst_trig_en", int'(bus.trig_en), 0);
        model_reset();
        cyc(2);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        cyc(1);

        // Second capture after a stopped one: address continuity
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
        cyc(7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        cyc(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
`ifdef CAPTURE_ADDR_CLR_EN
        exp_resume = 0;
`else
        exp_resume = 7;
`endif
        half(); cmp("resume_waddr", int'(bus.waddr), exp_resume); rest();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
